// File: rtl/renkon_conv_window3.sv
// renkon_conv_window3: 3x3 sliding-window producer for the convolution tree.
// Accepts a raster-order pixel stream, keeps two line buffers and a 3x3 shift
// window, and emits one registered window per valid (unpadded) position.
// Optional feature macro: RENKON_CONV_WINDOW_LAST_EN adds out_last, which
// marks the final window of a frame.
//
// state | meaning
// IDLE  | waiting for a start with legal sizes
// RUN   | accepting pixels, emitting windows
// DRAIN | all pixels taken, waiting for the final window handshake
module renkon_conv_window3 #(
  parameter int DWIDTH = 16,
  parameter int MAXW   = 32,
  parameter int CWIDTH = $clog2(MAXW + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CWIDTH-1:0]        img_w,
  input  logic [CWIDTH-1:0]        img_h,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DWIDTH-1:0] pixel_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DWIDTH-1:0] window [9],
  output logic                     busy,
`ifdef RENKON_CONV_WINDOW_LAST_EN
  output logic                     out_last,
`endif
  output logic                     done
);

  localparam int AW = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [CWIDTH-1:0]          w_q, h_q, col_q, row_q;
  logic signed [DWIDTH-1:0]   lb0_q [MAXW];
  logic signed [DWIDTH-1:0]   lb1_q [MAXW];
  logic signed [DWIDTH-1:0]   sh_q  [9];
  logic signed [DWIDTH-1:0]   sh_d  [9];
  logic signed [DWIDTH-1:0]   win_q [9];
  logic                       out_valid_q, done_q, done_d;
  logic                       sizes_ok, accept, col_last, row_last, produce, win_hs;
  logic [AW-1:0]              lb_addr;
`ifdef RENKON_CONV_WINDOW_LAST_EN
  logic                       last_q;
`endif

  assign lb_addr  = col_q[AW-1:0];
  assign sizes_ok = (img_w >= CWIDTH'(3)) && (img_w <= CWIDTH'(MAXW)) && (img_h >= CWIDTH'(3));
  assign col_last = (col_q == w_q - CWIDTH'(1));
  assign row_last = (row_q == h_q - CWIDTH'(1));
  assign win_hs   = out_valid_q && out_ready;
  assign accept   = in_valid && in_ready;
  assign produce  = accept && (row_q >= CWIDTH'(2)) && (col_q >= CWIDTH'(2));

  // Next-state and handshake control.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && sizes_ok) state_d = S_RUN;
      end
      S_RUN: begin
        in_ready = !out_valid_q || out_ready;
        if (in_valid && in_ready && col_last && row_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (win_hs) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Size latches, raster counters, output valid and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= done_d;
      if (state_q == S_IDLE && start && sizes_ok) begin
        w_q   <= img_w;
        h_q   <= img_h;
        col_q <= '0;
        row_q <= '0;
      end else if (accept) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + CWIDTH'(1);
        end else begin
          col_q <= col_q + CWIDTH'(1);
        end
      end
      if (produce)     out_valid_q <= 1'b1;
      else if (win_hs) out_valid_q <= 1'b0;
    end
  end

  // Shifted window: columns move left, new right column from the line buffers.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      sh_d[3*r]   = sh_q[3*r+1];
      sh_d[3*r+1] = sh_q[3*r+2];
    end
    sh_d[2] = lb1_q[lb_addr];
    sh_d[5] = lb0_q[lb_addr];
    sh_d[8] = pixel_in;
  end

  // Shift window and output window registers; output only loads on a real window.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        sh_q[i]  <= '0;
        win_q[i] <= '0;
      end
    end else begin
      if (accept)  sh_q  <= sh_d;
      if (produce) win_q <= sh_d;
    end
  end

  // Line buffers are never cleared; rows 0 and 1 always refill before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[lb_addr] <= lb0_q[lb_addr];
      lb0_q[lb_addr] <= pixel_in;
    end
  end

`ifdef RENKON_CONV_WINDOW_LAST_EN
  // Last-window flag travels with the window it belongs to.
  always_ff @(posedge clk) begin
    if (rst)          last_q <= 1'b0;
    else if (produce) last_q <= col_last && row_last;
  end

  assign out_last = last_q;
`endif

  assign window    = win_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_renkon_conv_window3.sv
// Bench for renkon_conv_window3: expected windows are built directly from the
// image array (window[3*r+c] = pixel(row-2+r, col-2+c)) and consumed in order.
module tb_renkon_conv_window3;
  localparam int DW   = 16;
  localparam int MAXW = 32;
  localparam int CW   = $clog2(MAXW + 1);

  logic                 clk = 1'b0;
  logic                 rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [CW-1:0]        img_w, img_h;
  logic signed [DW-1:0] pixel_in;
  logic signed [DW-1:0] window [9];
`ifdef RENKON_CONV_WINDOW_LAST_EN
  logic                 out_last;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  renkon_conv_window3 #(.DWIDTH(DW), .MAXW(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
    .out_valid(out_valid), .out_ready(out_ready), .window(window),
    .busy(busy),
`ifdef RENKON_CONV_WINDOW_LAST_EN
    .out_last(out_last),
`endif
    .done(done)
  );

  function automatic logic [9*DW-1:0] win_vec();
    logic [9*DW-1:0] v;
    for (int i = 0; i < 9; i++) v[i*DW +: DW] = window[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pxmode 0: pixels 0..n-1; 1: random with signed extremes.
  // rmode 0: ready=1; 1: toggle; 2: random; 3: 3-cycle stall on the final window.
  task automatic run_frame(input int w, input int h, input int pxmode, input int rmode, input int vprob);
    logic [DW-1:0]   pix [256];
    logic [9*DW-1:0] q [$];
    logic [9*DW-1:0] v;
    int              idx, n, stall, post;
    logic            exp_done, over, popped_last, ov, rdy, vld, exp_ir;
    n = w * h;
    for (int i = 0; i < n; i++) pix[i] = (pxmode == 0) ? DW'(i) : DW'($urandom);
    if (pxmode == 1) begin
      pix[0]       = 16'h8000;
      pix[w-1]     = 16'h7fff;
      pix[w]       = 16'h7fff;
      pix[2*w-1]   = 16'h8000;
      pix[n-1]     = 16'h8000;
    end
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            v[(3*i+j)*DW +: DW] = pix[(r-2+i)*w + (c-2+j)];
        q.push_back(v);
      end

    @(negedge clk);
    start = 1'b1; img_w = CW'(w); img_h = CW'(h); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", busy, 1'b1);

    idx = 0; stall = 0; post = 0; exp_done = 1'b0; over = 1'b0;
    for (int cyc = 0; cyc < 4000 && post < 3; cyc++) begin
      ov = out_valid;
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        2: rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(ov && q.size() == 1 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      vld = (idx < n) && ($urandom_range(1, 100) <= vprob);
      out_ready = rdy;
      in_valid  = vld;
      pixel_in  = vld ? pix[idx] : DW'($urandom);
      #1;
      exp_ir = (idx < n) && (!ov || rdy);
      chk("done", done, exp_done);
      chk("busy", busy, !(over || exp_done));
      chk("in_ready", in_ready, exp_ir);
      if (ov) begin
        chk("no_extra_window", q.size() > 0, 1'b1);
        if (q.size() > 0) chk("window", win_vec(), q[0]);
`ifdef RENKON_CONV_WINDOW_LAST_EN
        chk("out_last", out_last, q.size() == 1);
`endif
      end
      if (vld && exp_ir) idx++;
      popped_last = 1'b0;
      if (ov && rdy && q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) popped_last = 1'b1;
      end
      if (exp_done) over = 1'b1;
      exp_done = popped_last;
      if (over) post++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("frame_complete", over, 1'b1);
    chk("windows_left", q.size(), 0);
    chk("pixels_taken", idx, n);
  endtask

  task automatic try_illegal(input int w, input int h);
    @(negedge clk);
    start = 1'b1; img_w = CW'(w); img_h = CW'(h); in_valid = 1'b1; out_ready = 1'b1;
    pixel_in = DW'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("illegal_busy", busy, 1'b0);
      chk("illegal_in_ready", in_ready, 1'b0);
      chk("illegal_out_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic reset_mid();
    @(negedge clk);
    start = 1'b1; img_w = CW'(4); img_h = CW'(4);
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; pixel_in = DW'(i);
      #1;
      chk("rst_pre_in_ready", in_ready, 1'b1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_window", win_vec(), '0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; img_w = '0; img_h = '0;
    in_valid = 1'b0; out_ready = 1'b0; pixel_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_window", win_vec(), '0);
`ifdef RENKON_CONV_WINDOW_LAST_EN
    chk("reset_out_last", out_last, 1'b0);
`endif
    rst = 1'b0;

    run_frame(4, 4, 0, 0, 100);
    run_frame(5, 3, 0, 1, 100);
    try_illegal(2, 4);
    try_illegal(MAXW + 1, 4);
    try_illegal(4, 2);
    run_frame(3, 3, 0, 0, 100);
    run_frame(MAXW, 4, 1, 2, 80);
    reset_mid();
    run_frame(4, 4, 0, 0, 100);
    run_frame(4, 4, 0, 3, 100);
    for (int k = 0; k < 3; k++)
      run_frame(int'($urandom_range(3, MAXW)), int'($urandom_range(3, 6)), 1, 2, 70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
